game_timer_ctrl: RTL and testbench

Parametrised successor to the game countdown timer. Holds the remaining game time as whole seconds plus a millisecond fraction, with a one-cycle `done` pulse at expiry. Adds runtime-loadable game length, pause/resume, abort, a low-time warning flag, a per-second tick strobe and an optional bonus-time input. Sits between the game FSM (start/pause/abort) and the score/display logic (remaining time, warning, done).

---
 rtl/game_timer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: game countdown timer with runtime-loadable length, pause/resume,
// abort, a low-time warning flag, a per-second tick strobe and a one-cycle done pulse.
// Remaining time is kept as whole seconds plus a millisecond fraction.
// Optional feature: define GAME_TIMER_BONUS_EN to add the add_valid/add_seconds
// bonus-time inputs. The default build (macro undefined) has no bonus logic.
module game_timer_ctrl #(
  parameter  int GAME_LENGTH_SECONDS = 20,
  parameter  int MAX_SECONDS         = 99,
  parameter  int CLKS_PER_MS         = 50000,
  parameter  int MS_PER_SECOND       = 1000,
  parameter  int WARN_SECONDS        = 5,
  localparam int SEC_W               = $clog2(MAX_SECONDS + 1),
  localparam int MS_W                = $clog2(MAX_SECONDS * MS_PER_SECOND + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEC_W-1:0] start_seconds,
  input  logic             pause,
  input  logic             abort,
`ifdef GAME_TIMER_BONUS_EN
  input  logic             add_valid,
  input  logic [SEC_W-1:0] add_seconds,
`endif
  output logic [1:0]       state,
  output logic [SEC_W-1:0] seconds_left,
  output logic [MS_W-1:0]  ms_left,
  output logic             warning,
  output logic             second_tick,
  output logic             done
);

  localparam int PRE_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int FRAC_W = (MS_PER_SECOND > 1) ? $clog2(MS_PER_SECOND) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic               second_tick_q, second_tick_d;
  logic               done_q, done_d;
  logic               ms_tick;
  logic               expire;

  // Load value: 0 selects the default length; anything above the cap saturates.
  function automatic logic [SEC_W-1:0] sat_load(input logic [SEC_W-1:0] req);
    int v;
    v = (req == '0) ? GAME_LENGTH_SECONDS : int'(req);
    if (v > MAX_SECONDS) v = MAX_SECONDS;
    return SEC_W'(v);
  endfunction

`ifdef GAME_TIMER_BONUS_EN
  // Bonus add capped so total remaining time never exceeds MAX_SECONDS whole
  // seconds; MSB of the result flags that the cap was hit (fraction is dropped).
  function automatic logic [SEC_W:0] sat_bonus(input logic [SEC_W-1:0] sec,
                                               input logic             frac_nz,
                                               input logic [SEC_W-1:0] add);
    int total;
    total = int'(sec) + int'(add) + (frac_nz ? 1 : 0);
    if (total > MAX_SECONDS) return {1'b1, SEC_W'(MAX_SECONDS)};
    return {1'b0, SEC_W'(int'(sec) + int'(add))};
  endfunction

  logic [SEC_W:0] bonus_res;
`endif

  // Next-state logic: abort > start > pause/resume > ms tick (> bonus add).
  // Counting happens in any RUNNING/PAUSED cycle with pause low, so the cycle
  // that resumes from PAUSED already advances the prescaler.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    sec_d         = sec_q;
    frac_d        = frac_q;
    second_tick_d = 1'b0;
    done_d        = 1'b0;
    ms_tick       = 1'b0;
    expire        = 1'b0;
`ifdef GAME_TIMER_BONUS_EN
    bonus_res     = '0;
`endif
    if (abort) begin
      state_d = S_IDLE;
      presc_d = '0;
      sec_d   = '0;
      frac_d  = '0;
    end else if (start) begin
      state_d = S_RUNNING;
      presc_d = '0;
      sec_d   = sat_load(start_seconds);
      frac_d  = '0;
    end else if (state_q == S_RUNNING || state_q == S_PAUSED) begin
      if (pause) begin
        state_d = S_PAUSED;
      end else begin
        state_d = S_RUNNING;
        if (presc_q == PRE_W'(CLKS_PER_MS - 1)) begin
          presc_d = '0;
          ms_tick = 1'b1;
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      if (ms_tick) begin
        if (frac_q != '0) begin
          frac_d = frac_q - FRAC_W'(1);
          if (frac_q == FRAC_W'(1)) begin
            second_tick_d = 1'b1;
            expire        = (sec_q == '0);
          end
        end else if (sec_q != '0) begin
          sec_d  = sec_q - SEC_W'(1);
          frac_d = FRAC_W'(MS_PER_SECOND - 1);
        end
      end
`ifdef GAME_TIMER_BONUS_EN
      if (add_valid) begin
        bonus_res = sat_bonus(sec_d, frac_d != '0, add_seconds);
        sec_d     = bonus_res[SEC_W-1:0];
        if (bonus_res[SEC_W]) frac_d = '0;
        if (add_seconds != '0) expire = 1'b0;
      end
`endif
      if (expire) begin
        state_d = S_EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  // State, counters and the registered strobes; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      sec_q         <= '0;
      frac_q        <= '0;
      second_tick_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      sec_q         <= sec_d;
      frac_q        <= frac_d;
      second_tick_q <= second_tick_d;
      done_q        <= done_d;
    end
  end

  assign state        = state_q;
  assign second_tick  = second_tick_q;
  assign done         = done_q;
  assign ms_left      = MS_W'(sec_q) * MS_W'(MS_PER_SECOND) + MS_W'(frac_q);
  assign seconds_left = sec_q + SEC_W'(frac_q != '0);
  assign warning      = (WARN_SECONDS != 0) &&
                        (state_q == S_RUNNING || state_q == S_PAUSED) &&
                        (int'(seconds_left) <= WARN_SECONDS);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Randomized and directed bench for game_timer_ctrl against a total-milliseconds
// reference model. Covers the bonus inputs when GAME_TIMER_BONUS_EN is defined.
module tb_game_timer_ctrl;

  localparam int CPM   = 4;
  localparam int MSPS  = 10;
  localparam int GL    = 3;
  localparam int MAXS  = 7;
  localparam int WARN  = 1;
  localparam int SEC_W = $clog2(MAXS + 1);
  localparam int MS_W  = $clog2(MAXS * MSPS + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic [SEC_W-1:0] start_seconds;
  logic             pause;
  logic             abort;
`ifdef GAME_TIMER_BONUS_EN
  logic             add_valid;
  logic [SEC_W-1:0] add_seconds;
`endif
  logic [1:0]       state;
  logic [SEC_W-1:0] seconds_left;
  logic [MS_W-1:0]  ms_left;
  logic             warning;
  logic             second_tick;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining time as one integer of milliseconds.
  int m_state = 0;
  int m_ms    = 0;
  int m_presc = 0;
  int m_stick = 0;
  int m_done  = 0;

  game_timer_ctrl #(
    .GAME_LENGTH_SECONDS(GL),
    .MAX_SECONDS        (MAXS),
    .CLKS_PER_MS        (CPM),
    .MS_PER_SECOND      (MSPS),
    .WARN_SECONDS       (WARN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_seconds(start_seconds),
    .pause        (pause),
    .abort        (abort),
`ifdef GAME_TIMER_BONUS_EN
    .add_valid    (add_valid),
    .add_seconds  (add_seconds),
`endif
    .state        (state),
    .seconds_left (seconds_left),
    .ms_left      (ms_left),
    .warning      (warning),
    .second_tick  (second_tick),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ms = 0; m_presc = 0; m_stick = 0; m_done = 0;
  endtask

  // One clock edge of the reference model, using the inputs held for that edge.
  task automatic model_step();
    int s;
    bit tick;
    bit expd;
    tick = 0; expd = 0;
    m_stick = 0; m_done = 0;
    if (abort) begin
      m_state = 0; m_ms = 0; m_presc = 0;
    end else if (start) begin
      s = (start_seconds == 0) ? GL : int'(start_seconds);
      if (s > MAXS) s = MAXS;
      m_ms = s * MSPS; m_presc = 0; m_state = 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (pause) m_state = 2;
      else begin
        m_state = 1;
        m_presc++;
        if (m_presc == CPM) begin m_presc = 0; tick = 1; end
      end
      if (tick && m_ms > 0) begin
        m_ms--;
        if (m_ms % MSPS == 0) m_stick = 1;
        if (m_ms == 0) expd = 1;
      end
`ifdef GAME_TIMER_BONUS_EN
      if (add_valid) begin
        if (add_seconds != 0) expd = 0;
        m_ms = m_ms + int'(add_seconds) * MSPS;
        if (m_ms > MAXS * MSPS) m_ms = MAXS * MSPS;
      end
`endif
      if (expd) begin m_state = 3; m_done = 1; end
    end
  endtask

  task automatic check_all();
    int sl;
    int w;
    sl = (m_ms + MSPS - 1) / MSPS;
    w  = ((m_state == 1 || m_state == 2) && WARN != 0 && sl <= WARN) ? 1 : 0;
    chk("state", state, m_state);
    chk("ms_left", ms_left, m_ms);
    chk("seconds_left", seconds_left, sl);
    chk("warning", warning, w);
    chk("second_tick", second_tick, m_stick);
    chk("done", done, m_done);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load(input int secs);
    start = 1'b1; start_seconds = SEC_W'(secs);
    step();
    start = 1'b0;
  endtask

  // Advance until the model reaches the given ms/prescaler point (bounded).
  task automatic run_to(input string tag, input int ms, input int presc);
    for (int i = 0; i < 400 && !(m_ms == ms && m_presc == presc); i++) step();
    chk(tag, ms_left, ms);
  endtask

  initial begin
    int done_at;
    int sticks;
    int warn_ms;
    int gap;
    rst = 1'b0; start = 1'b0; start_seconds = '0; pause = 1'b0; abort = 1'b0;
`ifdef GAME_TIMER_BONUS_EN
    add_valid = 1'b0; add_seconds = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_ms", ms_left, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    step();

    // Full countdown with the default length.
    load(0);
    chk("load_ms", ms_left, 30);
    chk("load_sec", seconds_left, 3);
    done_at = -1; sticks = 0; warn_ms = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (k == 40) chk("ms_at_40", ms_left, 20);
      if (second_tick) sticks++;
      if (warning && warn_ms < 0) warn_ms = int'(ms_left);
      if (done) begin done_at = k; break; end
    end
    chk("done_latency", done_at, 120);
    chk("second_ticks", sticks, 3);
    chk("warn_rise_ms", warn_ms, 10);
    chk("exp_state", state, 3);
    chk("exp_warning", warning, 0);
    repeat (5) step();
    chk("exp_hold_ms", ms_left, 0);

    // Restart from EXPIRED, then abort mid-run.
    load(0);
    chk("reload_ms", ms_left, 30);
    repeat (20) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_ms", ms_left, 0);
    chk("abort_done", done, 0);

    // Largest representable load.
    load(MAXS);
    chk("max_load_ms", ms_left, 70);

    // Pause at ms_left=25, prescaler=2.
    load(0);
    run_to("pause_point", 25, 2);
    pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("paused_ms", ms_left, 25);
    end
    chk("paused_state", state, 2);
    pause = 1'b0;
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ms_left != 25) begin gap = i; break; end
    end
    chk("resume_gap", gap, 2);

    // Start and abort together.
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_state", state, 0);

    // Start while PAUSED with pause held.
    load(4);
    pause = 1'b1; step(); step();
    start = 1'b1; step(); start = 1'b0;
    chk("restart_run", state, 1);
    step();
    chk("restart_paused", state, 2);
    pause = 1'b0;

    // Asynchronous reset mid-run.
    load(5);
    repeat (10) step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_state", state, 0);
    chk("arst_ms", ms_left, 0);
    chk("arst_sec", seconds_left, 0);
    chk("arst_warn", warning, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

`ifdef GAME_TIMER_BONUS_EN
    load(3);
    run_to("bonus_a_pt", 15, 0);
    add_valid = 1'b1; add_seconds = 3'd2; step(); add_valid = 1'b0;
    chk("bonus_a_ms", ms_left, 35);
    load(5);
    run_to("bonus_b_pt", 45, 0);
    add_valid = 1'b1; add_seconds = 3'd5; step(); add_valid = 1'b0;
    chk("bonus_b_ms", ms_left, 70);
    load(1);
    run_to("bonus_c_pt", 1, 3);
    add_valid = 1'b1; add_seconds = 3'd1; step(); add_valid = 1'b0;
    chk("bonus_c_ms", ms_left, 10);
    chk("bonus_c_done", done, 0);
    chk("bonus_c_state", state, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 99) < ((m_state == 0 || m_state == 3) ? 10 : 1));
      start_seconds = SEC_W'($urandom_range(0, MAXS));
      abort = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 3) pause = ~pause;
`ifdef GAME_TIMER_BONUS_EN
      add_valid = ($urandom_range(0, 99) < 3);
      add_seconds = SEC_W'($urandom_range(0, MAXS));
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
